multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Cycle-level state machine that steps the multi-cycle processor through fetch, decode, execute, memory and write-back. It sits beside the combinational decode unit and gates that unit's static control fields into per-cycle strobes: IR load, PC update, register write and memory request. It waits on the memory ready handshake, resolves BEQ from the ALU zero flag and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- instr_type  in  2  IR type field: 00 R, 01 I, 10 J, 11 S
- opcode  in  5  IR opcode field
- mem_ready  in  1  memory handshake; request completes in the cycle it is high
- alu_zero  in  1  ALU zero flag, valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load IR
- dmem_req  out  1  data memory request
- dmem_wr  out  1  1 = store, 0 = load; meaningful only with dmem_req
- alu_en  out  1  ALU operand/result registers load
- rf_we  out  1  register-file write strobe
- link_we  out  1  write PC+1 to R7 (JAL)
- pc_we  out  1  PC load
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target
- state  out  3  current state, for debug
- error  out  1  illegal instruction seen; sticky
- retired  out  CNT_W  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5. Codes 6 and 7 → FETCH on the next edge.
- Outputs are combinational from state, instr_type, opcode, mem_ready and alu_zero. Unlisted outputs are 0.
- FETCH: imem_req=1.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: ir_we=1, go to DECODE.
- DECODE:
  - Legal set: R 00000–00011; I 00000–00100; S 00000–00011; J 00000 (J), 00001 (JAL).
  - J: pc_we=1, pc_src=10, go to FETCH.
  - JAL: pc_we=1, pc_src=10, link_we=1, go to FETCH.
  - Any other legal instruction: go to EXEC.
  - Illegal: go to ERROR.
- EXEC: alu_en=1.
  - BEQ (I 00100): pc_we=1, pc_src = alu_zero ? 01 : 00, go to FETCH.
  - CMP (R 00011): pc_we=1, pc_src=00, go to FETCH.
  - LW (I 00010), SW (I 00011): go to MEM.
  - Otherwise: go to WB.
- MEM: dmem_req=1; dmem_wr=1 for SW, 0 for LW.
  - mem_ready=0: stay in MEM.
  - mem_ready=1, SW: pc_we=1, pc_src=00, go to FETCH.
  - mem_ready=1, LW: go to WB.
- WB: rf_we=1, pc_we=1, pc_src=00, go to FETCH.
- ERROR: all strobes 0, error=1, stays in ERROR until reset.
- retired increments on every edge where pc_we=1. It wraps 2^CNT_W−1 → 0.
- instr_type/opcode must be stable from DECODE until the return to FETCH. The IR is loaded only in FETCH.

## Timing
- Reset, asynchronous:
  - state=FETCH, retired=0, error=0.
  - All strobes low while reset is high, including imem_req.
  - Reset asserted mid-instruction abandons it. No pc_we, rf_we or dmem_req is issued after assertion.
- First fetch request: imem_req rises in the first cycle after reset deasserts.
- Latency with zero-wait memory (mem_ready tied high), in cycles:
  - J/JAL: 2
  - BEQ, CMP: 3
  - R/I ALU ops, shifts, SW: 4
  - LW: 5
- Each low cycle of mem_ready in FETCH or MEM adds exactly one cycle.
- pc_we is asserted exactly once per instruction, in its final cycle. rf_we/link_we are asserted at most once.
- pc_we and ir_we are never high in the same cycle.
- BEQ samples alu_zero only in the EXEC cycle.
- Counter wrap coinciding with pc_we: retired goes to 0, no flag.

## Test plan
- Reset, then ADD (00, 00001), mem_ready=1 → states 0,1,2,4,0; rf_we and pc_we (pc_src=00) high in cycle 4 only; retired=1.
- LW (01, 00010), mem_ready low 2 cycles in MEM → MEM lasts 3 cycles with dmem_req=1, dmem_wr=0; then WB rf_we=1; total 7 cycles; retired +1.
- BEQ with alu_zero=1, then with alu_zero=0 → EXEC cycle shows pc_we=1 with pc_src=01, then 00; rf_we never high.
- JAL (10, 00001) → DECODE cycle has pc_we=1, pc_src=10, link_we=1; back in FETCH next cycle.
- Illegal (10, 00101) → ERROR with error=1; mem_ready toggling causes no strobes; reset → state 0, error 0.
- Assert reset during MEM of SW while mem_ready=0 → dmem_req drops immediately; no pc_we; retired=0. Then preload retired to 2^CNT_W−1 via 2^CNT_W−1 J instructions (CNT_W=4 build) → next J wraps retired to 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: per-cycle control for the multi-cycle processor.
// Steps FETCH -> DECODE -> EXEC -> MEM -> WB and turns the static decode
// fields into one-cycle strobes. It also counts retired instructions.
module multicycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       instr_type,
    input  logic [4:0]       opcode,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_wr,
    output logic             alu_en,
    output logic             rf_we,
    output logic             link_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam logic [1:0] T_R = 2'b00;
    localparam logic [1:0] T_I = 2'b01;
    localparam logic [1:0] T_J = 2'b10;
    localparam logic [1:0] T_S = 2'b11;

    localparam logic [1:0] SRC_INC = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JMP = 2'b10;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] retired_r;

    logic imem_req_s, ir_we_s, dmem_req_s, dmem_wr_s;
    logic alu_en_s, rf_we_s, link_we_s, pc_we_s;
    logic [1:0] pc_src_s;

    logic is_beq_s, is_cmp_s, is_lw_s, is_sw_s, is_jal_s;

    // Legal opcode ranges for each instruction type.
    function automatic logic is_legal(input logic [1:0] t, input logic [4:0] op);
        logic ok;
        case (t)
            T_R:     ok = (op <= 5'd3);
            T_I:     ok = (op <= 5'd4);
            T_J:     ok = (op <= 5'd1);
            T_S:     ok = (op <= 5'd3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign is_beq_s = (instr_type == T_I) && (opcode == 5'd4);
    assign is_cmp_s = (instr_type == T_R) && (opcode == 5'd3);
    assign is_lw_s  = (instr_type == T_I) && (opcode == 5'd2);
    assign is_sw_s  = (instr_type == T_I) && (opcode == 5'd3);
    assign is_jal_s = (instr_type == T_J) && (opcode == 5'd1);

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and raw strobe decode for the current state.
    always_comb begin
        state_nxt_s = state_r;
        imem_req_s  = 1'b0;
        ir_we_s     = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_wr_s   = 1'b0;
        alu_en_s    = 1'b0;
        rf_we_s     = 1'b0;
        link_we_s   = 1'b0;
        pc_we_s     = 1'b0;
        pc_src_s    = SRC_INC;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_we_s     = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!is_legal(instr_type, opcode)) begin
                    state_nxt_s = ST_ERROR;
                end else if (instr_type == T_J) begin
                    pc_we_s     = 1'b1;
                    pc_src_s    = SRC_JMP;
                    link_we_s   = is_jal_s;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en_s = 1'b1;
                if (is_beq_s) begin
                    pc_we_s     = 1'b1;
                    pc_src_s    = alu_zero ? SRC_BR : SRC_INC;
                    state_nxt_s = ST_FETCH;
                end else if (is_cmp_s) begin
                    pc_we_s     = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else if (is_lw_s || is_sw_s) begin
                    state_nxt_s = ST_MEM;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_wr_s  = is_sw_s;
                if (!mem_ready) begin
                    state_nxt_s = ST_MEM;
                end else if (is_sw_s) begin
                    pc_we_s     = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_WB: begin
                rf_we_s     = 1'b1;
                pc_we_s     = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            ST_ERROR: begin
                state_nxt_s = ST_ERROR;
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is held, even though state reads FETCH.
    assign imem_req = imem_req_s & ~reset;
    assign ir_we    = ir_we_s    & ~reset;
    assign dmem_req = dmem_req_s & ~reset;
    assign dmem_wr  = dmem_wr_s  & ~reset;
    assign alu_en   = alu_en_s   & ~reset;
    assign rf_we    = rf_we_s    & ~reset;
    assign link_we  = link_we_s  & ~reset;
    assign pc_we    = pc_we_s    & ~reset;
    assign pc_src   = reset ? SRC_INC : pc_src_s;
    assign state    = state_r;
    assign error    = (state_r == ST_ERROR);
    assign retired  = retired_r;

    // Retired counter: one count per PC update, wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (pc_we) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer built with a 4-bit retired counter.
// Expected per-cycle output vectors go through a scoreboard queue.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       instr_type;
    logic [4:0]       opcode;
    logic             mem_ready;
    logic             alu_zero;
    logic             imem_req, ir_we, dmem_req, dmem_wr, alu_en;
    logic             rf_we, link_we, pc_we, error;
    logic [1:0]       pc_src;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int vectors = 0;
    int miscompares = 0;
    logic [13:0] exp_q[$];

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_type(instr_type), .opcode(opcode),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .imem_req(imem_req),
        .ir_we(ir_we), .dmem_req(dmem_req), .dmem_wr(dmem_wr), .alu_en(alu_en),
        .rf_we(rf_we), .link_we(link_we), .pc_we(pc_we), .pc_src(pc_src),
        .state(state), .error(error), .retired(retired)
    );

    always #5 clk = ~clk;

    // Strobe order: imem_req ir_we dmem_req dmem_wr alu_en rf_we link_we pc_we
    function automatic logic [13:0] ev(input logic [2:0] st, input logic [7:0] s,
                                       input logic [1:0] src, input logic err);
        return {st, s, src, err};
    endfunction

    // Push the expectation, sample mid-cycle, pop and compare, then move to
    // 1 time unit after the next rising edge.
    task automatic cyc(input string tag, input logic [13:0] e);
        logic [13:0] obs, want;
        exp_q.push_back(e);
        #3;
        obs = {state, imem_req, ir_we, dmem_req, dmem_wr, alu_en, rf_we,
               link_we, pc_we, pc_src, error};
        want = exp_q.pop_front();
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ret(input string tag, input logic [CNT_W-1:0] e);
        vectors++;
        assert (retired === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, retired, e);
        end
    endtask

    task automatic set_ir(input logic [1:0] t, input logic [4:0] op);
        instr_type = t;
        opcode     = op;
    endtask

    initial begin
        reset = 1'b1; instr_type = 2'b00; opcode = 5'd0;
        mem_ready = 1'b0; alu_zero = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_hold", ev(3'd0, 8'b0000_0000, 2'b00, 1'b0));
        chk_ret("reset_retired", 4'd0);

        // ADD, zero-wait memory: 0,1,2,4
        reset = 1'b0; mem_ready = 1'b1; set_ir(2'b00, 5'd1);
        cyc("add_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("add_decode", ev(3'd1, 8'b0000_0000, 2'b00, 1'b0));
        cyc("add_exec",   ev(3'd2, 8'b0000_1000, 2'b00, 1'b0));
        cyc("add_wb",     ev(3'd4, 8'b0000_0101, 2'b00, 1'b0));
        chk_ret("add_retired", 4'd1);

        // LW with two wait cycles in MEM
        set_ir(2'b01, 5'd2);
        cyc("lw_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("lw_decode", ev(3'd1, 8'b0000_0000, 2'b00, 1'b0));
        cyc("lw_exec",   ev(3'd2, 8'b0000_1000, 2'b00, 1'b0));
        mem_ready = 1'b0;
        cyc("lw_mem_w0", ev(3'd3, 8'b0010_0000, 2'b00, 1'b0));
        cyc("lw_mem_w1", ev(3'd3, 8'b0010_0000, 2'b00, 1'b0));
        mem_ready = 1'b1;
        cyc("lw_mem_ok", ev(3'd3, 8'b0010_0000, 2'b00, 1'b0));
        cyc("lw_wb",     ev(3'd4, 8'b0000_0101, 2'b00, 1'b0));
        chk_ret("lw_retired", 4'd2);

        // BEQ taken: alu_zero only matters in EXEC
        set_ir(2'b01, 5'd4); alu_zero = 1'b0;
        cyc("beq1_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("beq1_decode", ev(3'd1, 8'b0000_0000, 2'b00, 1'b0));
        alu_zero = 1'b1;
        cyc("beq1_exec",   ev(3'd2, 8'b0000_1001, 2'b01, 1'b0));
        chk_ret("beq1_retired", 4'd3);
        // BEQ not taken, alu_zero high outside EXEC is ignored
        cyc("beq0_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("beq0_decode", ev(3'd1, 8'b0000_0000, 2'b00, 1'b0));
        alu_zero = 1'b0;
        cyc("beq0_exec",   ev(3'd2, 8'b0000_1001, 2'b00, 1'b0));
        chk_ret("beq0_retired", 4'd4);

        // CMP: three cycles
        set_ir(2'b00, 5'd3);
        cyc("cmp_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("cmp_decode", ev(3'd1, 8'b0000_0000, 2'b00, 1'b0));
        cyc("cmp_exec",   ev(3'd2, 8'b0000_1001, 2'b00, 1'b0));

        // JAL: two cycles, link write in DECODE
        set_ir(2'b10, 5'd1);
        cyc("jal_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("jal_decode", ev(3'd1, 8'b0000_0011, 2'b10, 1'b0));
        chk_ret("jal_retired", 4'd6);

        // Illegal instruction, fetch with one wait cycle first
        set_ir(2'b10, 5'd5); mem_ready = 1'b0;
        cyc("ill_fetch_w", ev(3'd0, 8'b1000_0000, 2'b00, 1'b0));
        mem_ready = 1'b1;
        cyc("ill_fetch",   ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("ill_decode",  ev(3'd1, 8'b0000_0000, 2'b00, 1'b0));
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0];
            cyc("ill_error", ev(3'd5, 8'b0000_0000, 2'b00, 1'b1));
        end
        chk_ret("ill_retired", 4'd6);
        reset = 1'b1;
        cyc("ill_reset", ev(3'd0, 8'b0000_0000, 2'b00, 1'b0));
        chk_ret("ill_reset_retired", 4'd0);

        // SW abandoned by reset while waiting in MEM
        reset = 1'b0; mem_ready = 1'b1; set_ir(2'b01, 5'd3);
        cyc("sw_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("sw_decode", ev(3'd1, 8'b0000_0000, 2'b00, 1'b0));
        cyc("sw_exec",   ev(3'd2, 8'b0000_1000, 2'b00, 1'b0));
        mem_ready = 1'b0;
        cyc("sw_mem_w",  ev(3'd3, 8'b0011_0000, 2'b00, 1'b0));
        reset = 1'b1;
        cyc("sw_reset",  ev(3'd0, 8'b0000_0000, 2'b00, 1'b0));
        chk_ret("sw_reset_retired", 4'd0);

        // Preload the counter with fifteen J instructions, then wrap
        reset = 1'b0; mem_ready = 1'b1; set_ir(2'b10, 5'd0);
        for (int i = 0; i < 15; i++) begin
            cyc("j_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
            cyc("j_decode", ev(3'd1, 8'b0000_0001, 2'b10, 1'b0));
        end
        chk_ret("j_preload", 4'd15);
        cyc("jwrap_fetch",  ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));
        cyc("jwrap_decode", ev(3'd1, 8'b0000_0001, 2'b10, 1'b0));
        chk_ret("j_wrap", 4'd0);
        cyc("post_wrap_fetch", ev(3'd0, 8'b1100_0000, 2'b00, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
